// File: rtl/loop_counter_nest.sv
// loop_counter_nest: cascaded loop counters with per-level limits, wrap/done pulses and start/busy control
module loop_counter_nest #(
    parameter int WIDTH  = 8,
    parameter int LEVELS = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    en,
    input  logic [LEVELS*WIDTH-1:0] limit,
    output logic [LEVELS*WIDTH-1:0] count,
    output logic [LEVELS-1:0]       last,
    output logic [LEVELS-1:0]       wrap,
    output logic                    busy,
    output logic                    done
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t                  state;
    logic [LEVELS*WIDTH-1:0] lim_q;
    logic [LEVELS*WIDTH-1:0] cnt_nxt;
    logic [LEVELS-1:0]       wrap_nxt;
    logic [LEVELS:0]         carry;
    assign busy = state == RUN;
    // terminal flags and carry chain: a level moves only when every faster level sits at its limit
    always_comb begin
        carry    = '0;
        carry[0] = 1'b1;
        cnt_nxt  = count;
        wrap_nxt = '0;
        last     = '0;
        for (int i = 0; i < LEVELS; i++) begin
            last[i]                   = busy && (count[i*WIDTH +: WIDTH] == lim_q[i*WIDTH +: WIDTH]);
            carry[i+1]                = carry[i] & last[i];
            wrap_nxt[i]               = carry[i] & last[i];
            cnt_nxt[i*WIDTH +: WIDTH] = !carry[i] ? count[i*WIDTH +: WIDTH] :
                                        last[i]   ? '0 : count[i*WIDTH +: WIDTH] + 1'b1;
        end
    end
    // control FSM and counter state; start outranks en, and a carry out of the top level ends the run
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            lim_q <= '0;
            wrap  <= '0;
            done  <= 1'b0;
        end else begin
            wrap <= '0;
            done <= 1'b0;
            if (start) begin
                state <= RUN;
                lim_q <= limit;
                count <= '0;
            end else if (busy && en) begin
                count <= cnt_nxt;
                wrap  <= wrap_nxt;
                done  <= carry[LEVELS];
                if (carry[LEVELS]) state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_loop_counter_nest.sv
// tb_loop_counter_nest: scoreboard bench for the nested loop counter (3-level and 1-level builds)
module tb_loop_counter_nest;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, en = 1'b0;
    logic [23:0] limit = '0;
    logic [23:0] count;
    logic [2:0]  last, wrap;
    logic        busy, done;
    logic        start1 = 1'b0, en1 = 1'b0;
    logic [7:0]  limit1 = '0, count1;
    logic        last1, wrap1, busy1, done1;
    int          checks = 0, failures = 0;
    logic [31:0] exp_q[$];
    int          m_cnt[3], m_lim[3];
    logic        m_busy = 1'b0;

    loop_counter_nest #(.WIDTH(8), .LEVELS(3)) dut (
        .clk(clk), .rst(rst), .start(start), .en(en), .limit(limit),
        .count(count), .last(last), .wrap(wrap), .busy(busy), .done(done)
    );
    loop_counter_nest #(.WIDTH(8), .LEVELS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .en(en1), .limit(limit1),
        .count(count1), .last(last1), .wrap(wrap1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] obs();
        return {count, wrap, done, busy, last};
    endfunction

    function automatic logic [23:0] lim3(input int a0, input int a1, input int a2);
        return {a2[7:0], a1[7:0], a0[7:0]};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0;
            m_lim[i] = 0;
        end
        m_busy = 1'b0;
        exp_q.delete();
    endtask

    // odometer-style reference: push the outputs expected after the next edge
    task automatic step(input logic s, input logic e, input logic [23:0] l);
        logic [2:0] w, lst;
        logic       d;
        w = '0;
        d = 1'b0;
        if (s) begin
            for (int i = 0; i < 3; i++) begin
                m_lim[i] = int'(l[i*8 +: 8]);
                m_cnt[i] = 0;
            end
            m_busy = 1'b1;
        end else if (m_busy && e) begin
            for (int i = 0; i < 3; i++) begin
                if (m_cnt[i] == m_lim[i]) begin
                    m_cnt[i] = 0;
                    w[i] = 1'b1;
                    if (i == 2) begin
                        d = 1'b1;
                        m_busy = 1'b0;
                    end
                end else begin
                    m_cnt[i] = (m_cnt[i] + 1) % 256;
                    break;
                end
            end
        end
        for (int i = 0; i < 3; i++) lst[i] = m_busy && (m_cnt[i] == m_lim[i]);
        exp_q.push_back({m_cnt[2][7:0], m_cnt[1][7:0], m_cnt[0][7:0], w, d, m_busy, lst});
        start = s;
        en    = e;
        limit = l;
        @(posedge clk);
        #1;
        start = 1'b0;
        en    = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] ex;
        checks++;
        if (obs() !== 32'h0) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h", obs(), 32'h0);
        end
        rst = 1'b0;
        model_clear();
        step(1'b1, 1'b0, lim3(3, 3, 3));
        for (int k = 0; k < 10; k++) begin
            ex = exp_q.pop_front();
            checks++;
            if (obs() !== ex) begin
                failures++;
                $display("FAIL reset_run step=%0d got=%h exp=%h", k, obs(), ex);
            end
            if (k < 9) step(1'b0, 1'b1, lim3(3, 3, 3));
        end
        checks++;
        if (count !== {8'd0, 8'd2, 8'd1}) begin
            failures++;
            $display("FAIL reset_precount got=%h exp=%h", count, {8'd0, 8'd2, 8'd1});
        end
        rst = 1'b1;
        #1;
        checks++;
        if (obs() !== 32'h0 || count1 !== 8'h0 || busy1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_async got=%h exp=%h", obs(), 32'h0);
        end
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_idle_en();
        logic [31:0] ex;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, lim3(5, 5, 5));
            ex = exp_q.pop_front();
            checks++;
            if (obs() !== ex) begin
                failures++;
                $display("FAIL idle_en step=%0d got=%h exp=%h", k, obs(), ex);
            end
        end
    endtask

    task automatic test_full_sweep();
        logic [31:0] ex;
        int adv, dn, wc[3];
        bit fin;
        adv = 0; dn = 0; fin = 0;
        wc[0] = 0; wc[1] = 0; wc[2] = 0;
        step(1'b1, 1'b0, lim3(2, 1, 3));
        ex = exp_q.pop_front();
        checks++;
        if (obs() !== ex) begin
            failures++;
            $display("FAIL sweep_start got=%h exp=%h", obs(), ex);
        end
        for (int k = 0; k < 100 && !fin; k++) begin
            step(1'b0, 1'b1, lim3(2, 1, 3));
            adv++;
            ex = exp_q.pop_front();
            checks++;
            if (obs() !== ex) begin
                failures++;
                $display("FAIL sweep adv=%0d got=%h exp=%h", adv, obs(), ex);
            end
            for (int i = 0; i < 3; i++) if (wrap[i]) wc[i]++;
            if (done) begin
                dn++;
                fin = 1;
            end
        end
        checks++;
        if (adv !== 24 || dn !== 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL sweep_len got=%0d/%0d/%b exp=24/1/0", adv, dn, busy);
        end
        checks++;
        if (wc[0] !== 8 || wc[1] !== 4 || wc[2] !== 1) begin
            failures++;
            $display("FAIL sweep_wraps got=%0d,%0d,%0d exp=8,4,1", wc[0], wc[1], wc[2]);
        end
        step(1'b1, 1'b0, lim3(1, 0, 0));
        ex = exp_q.pop_front();
        checks++;
        if (obs() !== ex || busy !== 1'b1) begin
            failures++;
            $display("FAIL start_after_done got=%h exp=%h", obs(), ex);
        end
    endtask

    task automatic test_gapped();
        logic [31:0] ex;
        logic e;
        int acc;
        bit fin;
        acc = 0; fin = 0;
        step(1'b1, 1'b0, lim3(3, 0, 2));
        void'(exp_q.pop_front());
        for (int k = 0; k < 200 && !fin; k++) begin
            e = 1'($urandom_range(0, 1));
            if (e) acc++;
            step(1'b0, e, lim3(3, 0, 2));
            ex = exp_q.pop_front();
            checks++;
            if (obs() !== ex) begin
                failures++;
                $display("FAIL gapped cyc=%0d got=%h exp=%h", k, obs(), ex);
            end
            if (done) fin = 1;
        end
        checks++;
        if (acc !== 12 || !fin) begin
            failures++;
            $display("FAIL gapped_len got=%0d exp=12", acc);
        end
    endtask

    task automatic test_extremes();
        logic [31:0] ex;
        bit fin;
        step(1'b1, 1'b0, lim3(0, 0, 0));
        void'(exp_q.pop_front());
        step(1'b0, 1'b1, lim3(0, 0, 0));
        ex = exp_q.pop_front();
        checks++;
        if (obs() !== ex || wrap !== 3'b111 || done !== 1'b1) begin
            failures++;
            $display("FAIL zero_limits got=%h exp=%h", obs(), ex);
        end
        fin = 0;
        step(1'b1, 1'b0, lim3(255, 0, 0));
        void'(exp_q.pop_front());
        for (int k = 1; k <= 256; k++) begin
            step(1'b0, 1'b1, lim3(255, 0, 0));
            ex = exp_q.pop_front();
            checks++;
            if (obs() !== ex) begin
                failures++;
                $display("FAIL full_range adv=%0d got=%h exp=%h", k, obs(), ex);
            end
            if (done) fin = (k == 256);
        end
        checks++;
        if (!fin) begin
            failures++;
            $display("FAIL full_range_done got=0 exp=1");
        end
    endtask

    task automatic test_restart();
        logic [31:0] ex;
        step(1'b1, 1'b0, lim3(1, 1, 1));
        void'(exp_q.pop_front());
        for (int k = 1; k <= 7; k++) begin
            step(1'b0, 1'b1, (k > 3) ? lim3(0, 0, 0) : lim3(1, 1, 1));
            ex = exp_q.pop_front();
            checks++;
            if (obs() !== ex) begin
                failures++;
                $display("FAIL restart_run adv=%0d got=%h exp=%h", k, obs(), ex);
            end
        end
        step(1'b1, 1'b1, lim3(2, 0, 0));
        ex = exp_q.pop_front();
        checks++;
        if (obs() !== ex || done !== 1'b0 || busy !== 1'b1 || count !== 24'h0) begin
            failures++;
            $display("FAIL restart_prio got=%h exp=%h", obs(), ex);
        end
        for (int k = 1; k <= 3; k++) begin
            step(1'b0, 1'b1, lim3(7, 7, 7));
            ex = exp_q.pop_front();
            checks++;
            if (obs() !== ex || done !== (k == 3)) begin
                failures++;
                $display("FAIL restart_new adv=%0d got=%h exp=%h", k, obs(), ex);
            end
        end
    endtask

    task automatic test_single_level();
        logic [11:0] got, ex;
        start1 = 1'b1;
        limit1 = 8'd4;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        limit1 = 8'd9;
        for (int k = 1; k <= 5; k++) begin
            en1 = 1'b1;
            @(posedge clk);
            #1;
            en1 = 1'b0;
            got = {count1, last1, wrap1, busy1, done1};
            ex  = {8'(k % 5), k == 4, k == 5, k != 5, k == 5};
            checks++;
            if (got !== ex) begin
                failures++;
                $display("FAIL single adv=%0d got=%h exp=%h", k, got, ex);
            end
        end
    endtask

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_idle_en();
        test_full_sweep();
        test_gapped();
        test_extremes();
        test_restart();
        test_single_level();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
